memory_access: RTL and testbench
================================

# memory_access

Pipeline MEM stage of the MIPS core. Consumes the EX/MEM latch fields (ALU result, store data, destination register, MEM/WB control), performs byte/half/word loads and stores against an internal little-endian data memory with sign/zero extension, and registers the MEM/WB latch for the writeback stage. It also exposes a word-wide debug read port used by the debug unit while the pipeline is halted.

## Interface
- NB_DATA, 32, data/address width
- NB_ADDR, 8, word-address bits (memory depth 2**NB_ADDR words)
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline advance; 0 = stall (hold MEM/WB outputs, suppress store)
- i_ALU_result  in  NB_DATA  byte address for loads/stores; pass-through value for WB
- i_data_to_write_in_MEM  in  NB_DATA  store data (low byte/half used for sb/sh)
- i_write_reg  in  5  destination register
- i_WB_write  in  1  writeback enable
- i_WB_mem_to_reg  in  1  0 = WB takes memory data, 1 = WB takes ALU result
- i_MEM_read  in  1  load
- i_MEM_write  in  1  store
- i_MEM_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- i_MEM_byte_half_word  in  2  00 byte, 01 half, 11 word, 10 reserved (treated as word)
- i_debug_addr  in  NB_ADDR  debug word address
- o_debug_data  out  NB_DATA  combinational word at i_debug_addr
- o_WB_write  out  1  registered
- o_WB_mem_to_reg  out  1  registered
- o_write_reg  out  5  registered
- o_ALU_result  out  NB_DATA  registered pass-through
- o_mem_data  out  NB_DATA  registered extended load data
- o_misaligned  out  1  registered, 1 for the cycle following a misaligned access

## Operation
- Word index = i_ALU_result[NB_ADDR+1:2]; higher address bits ignored (wrap modulo depth). Lane = i_ALU_result[1:0], little-endian (lane 0 = bits 7:0).
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00; byte always aligned.
- Store (i_MEM_write=1, aligned, i_enable=1, i_reset=0): byte writes lane addr[1:0] with data[7:0]; half writes lanes {addr[1],0}/{addr[1],1} with data[15:0]; word writes all lanes. Other lanes untouched.
- Load (i_MEM_read=1, aligned): select byte/half/word from the addressed word, extend per i_MEM_unsigned, register into o_mem_data.
- Misaligned load or store: no memory write, o_mem_data = 0, o_misaligned = 1. Control fields still pass through.
- Non-load cycles: o_mem_data = 0.
- i_MEM_read and i_MEM_write both 1: store performed, o_mem_data = 0.
- Memory array is not cleared by reset; simulation initialises it to zero.

## Timing
- Reset: all outputs 0 on the edge after i_reset sampled high; a store presented in a reset cycle is suppressed.
- Latency 1 cycle: inputs sampled at edge N appear on MEM/WB outputs after edge N.
- Memory read is asynchronous against the array; write is synchronous. A load in the cycle after a store to the same word returns the new data.
- o_debug_data reflects array contents combinationally; same-cycle store is visible only after the write edge.
- i_enable=0: outputs hold, no store, o_misaligned holds.

## Structure
- Shared package: size encodings (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b11), lane constants.
- Sub-module data_memory: byte-lane-enable synchronous-write RAM, async read, second async debug read port. memory_access holds alignment check, lane/byte-enable generation, load extraction/extension and the MEM/WB register.

## Test plan
- sw 0xDEADBEEF at addr 0x10, then lw 0x10 -> o_mem_data = 0xDEADBEEF one cycle after load; o_debug_data at word 4 = 0xDEADBEEF.
- sb 0x11,0x22,0x33,0x44 at 0x20..0x23, then lw 0x20 -> 0x44332211.
- Word 0x00008080 at 0x30: lb 0x30 -> 0xFFFFFF80; lbu -> 0x00000080; lh -> 0xFFFF8080; lhu -> 0x00008080.
- lh at 0x31 and sw at 0x32 -> o_misaligned=1, o_mem_data=0, memory unchanged.
- sw with i_reset=1 -> memory unchanged, all outputs 0; i_enable=0 with a sw -> no write, outputs hold previous values.
- i_WB_mem_to_reg=1, i_ALU_result=0x1234, i_write_reg=7, i_WB_write=1 -> next cycle o_ALU_result=0x1234, o_write_reg=7, o_WB_write=1.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared encodings and helpers for the MEM stage: access sizes, byte lanes,
// alignment, byte-enable generation and load extraction/extension.
package memory_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_RSVD = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam int NB_LANE  = 8;
  localparam int NB_LANES = 4;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  typedef struct packed {
    logic       wb_write;
    logic       mem_to_reg;
    logic [4:0] write_reg;
  } wb_ctrl_t;

  // The reserved encoding behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == SIZE_RSVD) ? SIZE_WORD : size;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    ok = 1'b1;
    case (norm_size(size))
      SIZE_HALF: ok = (lane[0] == 1'b0);
      SIZE_WORD: ok = (lane == LANE_0);
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [NB_LANES-1:0] lane_enables(input logic [1:0] size,
                                                       input logic [1:0] lane);
    logic [NB_LANES-1:0] be;
    be = '0;
    case (norm_size(size))
      SIZE_BYTE: be[lane] = 1'b1;
      SIZE_HALF: begin
        be[{lane[1], 1'b0}] = 1'b1;
        be[{lane[1], 1'b1}] = 1'b1;
      end
      default:   be = '1;
    endcase
    return be;
  endfunction

  // Replicating the low byte/half across the word lets the byte enables alone
  // pick which lanes actually change.
  function automatic logic [31:0] store_replicate(input logic [1:0] size,
                                                  input logic [31:0] data);
    logic [31:0] w;
    case (norm_size(size))
      SIZE_BYTE: w = {4{data[7:0]}};
      SIZE_HALF: w = {2{data[15:0]}};
      default:   w = data;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[lane*NB_LANE +: NB_LANE];
    h = lane[1] ? word[31:16] : word[15:0];
    case (norm_size(size))
      SIZE_BYTE: r = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
      SIZE_HALF: r = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_access_data_memory.sv
// Little-endian word RAM: byte-lane synchronous write, asynchronous read
// port for the pipeline and a second asynchronous read port for debug.
module data_memory
  import memory_access_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic                  i_clk,
  input  logic [NB_DATA/8-1:0]  i_byte_en,
  input  logic [NB_ADDR-1:0]    i_addr,
  input  logic [NB_DATA-1:0]    i_wdata,
  output logic [NB_DATA-1:0]    o_rdata,
  input  logic [NB_ADDR-1:0]    i_debug_addr,
  output logic [NB_DATA-1:0]    o_debug_data
);

  localparam int DEPTH = 1 << NB_ADDR;
  localparam int LANES = NB_DATA / 8;

  // Contents survive reset; the declaration value gives a zeroed array at start.
  logic [NB_DATA-1:0] r_mem [DEPTH] = '{default: '0};

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (i_byte_en[k]) begin
        r_mem[i_addr][k*8 +: 8] <= i_wdata[k*8 +: 8];
      end
    end
  end

  assign o_rdata      = r_mem[i_addr];
  assign o_debug_data = r_mem[i_debug_addr];

endmodule

// File: rtl/memory_access.sv
// MIPS MEM stage: load/store against the data memory with sign/zero
// extension, misalignment detection and the registered MEM/WB latch.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_DATA-1:0] i_ALU_result,
  input  logic [NB_DATA-1:0] i_data_to_write_in_MEM,
  input  logic [4:0]         i_write_reg,
  input  logic               i_WB_write,
  input  logic               i_WB_mem_to_reg,
  input  logic               i_MEM_read,
  input  logic               i_MEM_write,
  input  logic               i_MEM_unsigned,
  input  logic [1:0]         i_MEM_byte_half_word,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic [NB_DATA-1:0] o_debug_data,
  output logic               o_WB_write,
  output logic               o_WB_mem_to_reg,
  output logic [4:0]         o_write_reg,
  output logic [NB_DATA-1:0] o_ALU_result,
  output logic [NB_DATA-1:0] o_mem_data,
  output logic               o_misaligned
);

  // No handshake: i_enable=1 advances the stage each cycle; i_enable=0 holds
  // every MEM/WB output and blocks the store. Reset overrides both.

  logic [NB_ADDR-1:0]   w_word_idx;
  logic [1:0]           w_lane;
  logic                 w_aligned;
  logic                 w_access;
  logic                 w_misaligned;
  logic                 w_store;
  logic                 w_load;
  logic [NB_LANES-1:0]  w_byte_en;
  logic [NB_DATA-1:0]   w_wdata;
  logic [NB_DATA-1:0]   w_rdata;
  logic [NB_DATA-1:0]   w_load_data;
  wb_ctrl_t             w_ctrl;

  logic [NB_DATA-1:0]   r_ALU_result;
  logic [NB_DATA-1:0]   r_mem_data;
  logic                 r_misaligned;
  wb_ctrl_t             r_ctrl;

  assign w_word_idx   = i_ALU_result[NB_ADDR+1:2];
  assign w_lane       = i_ALU_result[1:0];
  assign w_aligned    = is_aligned(i_MEM_byte_half_word, w_lane);
  assign w_access     = i_MEM_read | i_MEM_write;
  assign w_misaligned = w_access & ~w_aligned;

  assign w_store   = i_MEM_write & w_aligned & i_enable & ~i_reset;
  // A simultaneous read+write request is treated as a store only.
  assign w_load    = i_MEM_read & ~i_MEM_write & w_aligned;
  assign w_byte_en = w_store ? lane_enables(i_MEM_byte_half_word, w_lane) : '0;
  assign w_wdata   = store_replicate(i_MEM_byte_half_word, i_data_to_write_in_MEM);

  assign w_load_data = w_load ? load_extract(w_rdata, i_MEM_byte_half_word,
                                             w_lane, i_MEM_unsigned)
                              : '0;

  assign w_ctrl = '{wb_write:   i_WB_write,
                    mem_to_reg: i_WB_mem_to_reg,
                    write_reg:  i_write_reg};

  data_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .i_clk        (i_clk),
    .i_byte_en    (w_byte_en),
    .i_addr       (w_word_idx),
    .i_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .i_debug_addr (i_debug_addr),
    .o_debug_data (o_debug_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ctrl       <= '0;
      r_ALU_result <= '0;
      r_mem_data   <= '0;
      r_misaligned <= 1'b0;
    end else if (i_enable) begin
      r_ctrl       <= w_ctrl;
      r_ALU_result <= i_ALU_result;
      r_mem_data   <= w_load_data;
      r_misaligned <= w_misaligned;
    end
  end

  assign o_WB_write      = r_ctrl.wb_write;
  assign o_WB_mem_to_reg = r_ctrl.mem_to_reg;
  assign o_write_reg     = r_ctrl.write_reg;
  assign o_ALU_result    = r_ALU_result;
  assign o_mem_data      = r_mem_data;
  assign o_misaligned    = r_misaligned;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: driver pushes hand-computed MEM/WB values
// into a queue, a monitor pops one per cycle and compares.
module tb_memory_access;

  localparam int W = 72;  // {wb, m2r, reg[5], alu[32], mem[32], mis}

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] alu;
  logic [31:0] wdata;
  logic [4:0]  wreg;
  logic        wb;
  logic        m2r;
  logic        rd;
  logic        wr;
  logic        uns;
  logic [1:0]  sz;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        o_wb;
  logic        o_m2r;
  logic [4:0]  o_reg;
  logic [31:0] o_alu;
  logic [31:0] o_mem;
  logic        o_mis;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int checks;
  int errors;

  memory_access dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_enable               (en),
    .i_ALU_result           (alu),
    .i_data_to_write_in_MEM (wdata),
    .i_write_reg            (wreg),
    .i_WB_write             (wb),
    .i_WB_mem_to_reg        (m2r),
    .i_MEM_read             (rd),
    .i_MEM_write            (wr),
    .i_MEM_unsigned         (uns),
    .i_MEM_byte_half_word   (sz),
    .i_debug_addr           (dbg_addr),
    .o_debug_data           (dbg_data),
    .o_WB_write             (o_wb),
    .o_WB_mem_to_reg        (o_m2r),
    .o_write_reg            (o_reg),
    .o_ALU_result           (o_alu),
    .o_mem_data             (o_mem),
    .o_misaligned           (o_mis)
  );

  // Clock / initial input values
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1; en = 1'b0; alu = '0; wdata = '0; wreg = '0; wb = 1'b0;
    m2r = 1'b0; rd = 1'b0; wr = 1'b0; uns = 1'b0; sz = 2'b11; dbg_addr = '0;
  end

  // Driver: one call = one cycle of stimulus plus its expected MEM/WB value.
  task automatic drive(input logic d_en, input logic d_rst, input logic d_rd,
                       input logic d_wr, input logic d_uns, input logic [1:0] d_sz,
                       input logic [31:0] d_alu, input logic [31:0] d_wdata,
                       input logic [4:0] d_reg, input logic d_wb, input logic d_m2r,
                       input logic [31:0] exp_mem, input logic exp_mis);
    logic [W-1:0] e;
    @(negedge clk);
    en = d_en; rst = d_rst; rd = d_rd; wr = d_wr; uns = d_uns; sz = d_sz;
    alu = d_alu; wdata = d_wdata; wreg = d_reg; wb = d_wb; m2r = d_m2r;
    if (d_rst)      e = '0;
    else if (!d_en) e = last_exp;
    else            e = {d_wb, d_m2r, d_reg, d_alu, exp_mem, exp_mis};
    last_exp = e;
    exp_q.push_back(e);
  endtask

  task automatic store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                       input logic exp_mis);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s, a, d, 5'd0, 1'b0, 1'b0, 32'd0, exp_mis);
  endtask

  task automatic load(input logic [1:0] s, input logic u, input logic [31:0] a,
                      input logic [4:0] r, input logic [31:0] exp_mem, input logic exp_mis);
    drive(1'b1, 1'b0, 1'b1, 1'b0, u, s, a, 32'hFFFF_FFFF, r, 1'b1, 1'b0, exp_mem, exp_mis);
  endtask

  task automatic nop();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic check_dbg(input logic [7:0] a, input logic [31:0] exp_v);
    dbg_addr = a;
    #1;
    checks++;
    if (dbg_data !== exp_v) begin
      errors++;
      $display("FAIL debug[%0d] got %h exp %h", a, dbg_data, exp_v);
    end
  endtask

  // Monitor: the registered outputs are compared just after each active edge.
  always @(posedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] g;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {o_wb, o_m2r, o_reg, o_alu, o_mem, o_mis};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL mem_wb t=%0t got wb=%b m2r=%b reg=%0d alu=%h mem=%h mis=%b exp wb=%b m2r=%b reg=%0d alu=%h mem=%h mis=%b",
                 $time, g[71], g[70], g[69:65], g[64:33], g[32:1], g[0],
                 e[71], e[70], e[69:65], e[64:33], e[32:1], e[0]);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    last_exp = '0;
    // reset
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    // word store then immediate load
    store(2'b11, 32'h10, 32'hDEAD_BEEF, 1'b0);
    load(2'b11, 1'b0, 32'h10, 5'd2, 32'hDEAD_BEEF, 1'b0);
    check_dbg(8'd4, 32'hDEAD_BEEF);
    // byte stores assemble a word
    store(2'b00, 32'h20, 32'hCDCD_CD11, 1'b0);
    store(2'b00, 32'h21, 32'hCDCD_CD22, 1'b0);
    store(2'b00, 32'h22, 32'hCDCD_CD33, 1'b0);
    store(2'b00, 32'h23, 32'hCDCD_CD44, 1'b0);
    load(2'b11, 1'b0, 32'h20, 5'd3, 32'h4433_2211, 1'b0);
    // extension cases
    store(2'b11, 32'h30, 32'h0000_8080, 1'b0);
    load(2'b00, 1'b0, 32'h30, 5'd4, 32'hFFFF_FF80, 1'b0);
    load(2'b00, 1'b1, 32'h30, 5'd4, 32'h0000_0080, 1'b0);
    load(2'b01, 1'b0, 32'h30, 5'd4, 32'hFFFF_8080, 1'b0);
    load(2'b01, 1'b1, 32'h30, 5'd4, 32'h0000_8080, 1'b0);
    load(2'b00, 1'b0, 32'h31, 5'd5, 32'hFFFF_FF80, 1'b0);
    load(2'b01, 1'b1, 32'h32, 5'd5, 32'h0000_0000, 1'b0);
    // half store into upper lanes
    store(2'b01, 32'h36, 32'h1234_BEEF, 1'b0);
    load(2'b11, 1'b0, 32'h34, 5'd6, 32'hBEEF_0000, 1'b0);
    // misaligned accesses, then a stall that must hold o_misaligned
    load(2'b01, 1'b0, 32'h31, 5'd8, 32'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h44, 32'h5555_AAAA, 5'd9, 1'b0, 1'b0, 32'd0, 1'b0);
    store(2'b11, 32'h32, 32'hFFFF_FFFF, 1'b1);
    load(2'b11, 1'b0, 32'h33, 5'd8, 32'd0, 1'b1);
    load(2'b11, 1'b0, 32'h30, 5'd8, 32'h0000_8080, 1'b0);
    check_dbg(8'd12, 32'h0000_8080);
    check_dbg(8'd17, 32'h0000_0000);
    // reserved size acts as word; address wraps modulo depth
    load(2'b10, 1'b0, 32'h10, 5'd10, 32'hDEAD_BEEF, 1'b0);
    store(2'b11, 32'h410, 32'h0BAD_F00D, 1'b0);
    load(2'b11, 1'b0, 32'h10, 5'd10, 32'h0BAD_F00D, 1'b0);
    check_dbg(8'd4, 32'h0BAD_F00D);
    // read and write together: store wins, no load data
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 32'h50, 32'h0000_0077, 5'd11, 1'b1, 1'b0, 32'd0, 1'b0);
    load(2'b11, 1'b0, 32'h50, 5'd11, 32'h0000_0077, 1'b0);
    // store during reset is suppressed
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 32'h40, 32'hAAAA_5555, 5'd12, 1'b1, 1'b1, 32'd0, 1'b0);
    nop();
    check_dbg(8'd16, 32'h0000_0000);
    // ALU pass-through
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 32'h1234, 32'd0, 5'd7, 1'b1, 1'b1, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h48, 32'h1357_9BDF, 5'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    nop();
    check_dbg(8'd18, 32'h0000_0000);
    nop();
    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
